bin_to_bcd_conv: RTL and testbench

//   Sequential double-dabble converter: binary value (0..10^DIGITS-1) -> packed BCD digits.

---
 rtl/bin_to_bcd_conv.sv | 127 ++++++++++++
 tb/tb_bin_to_bcd_conv.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_conv
//  Purpose  : Sequential double-dabble binary-to-packed-BCD converter feeding
//             the 7-segment display driver. One conversion takes BIN_W shift
//             cycles; inputs above 10^DIGITS-1 saturate and flag overflow.
//  Revision : 1.0  initial release
// ============================================================================
module bin_to_bcd_conv #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf
);

    // Largest displayable value, computed at elaboration. It must fit in
    // BIN_W bits or saturation would clip to a wrong value.
    function automatic int unsigned f_pow10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam int unsigned            c_MAX_INT  = f_pow10(DIGITS) - 1;
    localparam logic [BIN_W-1:0]       c_MAX      = c_MAX_INT[BIN_W-1:0];
    localparam int                     CNT_W      = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0]       c_CNT_INIT = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0]       c_CNT_LAST = CNT_W'(1);
    localparam int                     SCR_W      = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [BIN_W-1:0]  r_shift;
    logic [SCR_W-1:0]  r_scr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf_pend;
    logic [SCR_W-1:0]  r_out_bcd;
    logic              r_out_ovf;
    logic [SCR_W-1:0]  w_adj;
    logic [SCR_W-1:0]  w_scr_nxt;
    logic              w_accept;
    logic              w_last;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == c_CNT_LAST);
    // Adjusted scratch shifted left, with the next binary bit entering at LSB.
    assign w_scr_nxt = {w_adj[SCR_W-2:0], r_shift[BIN_W-1]};

    // Per-digit add-3 correction; nibbles are independent, no carry between them.
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_adj
            assign w_adj[4*k +: 4] = (r_scr[4*k +: 4] >= 4'd5) ?
                                     (r_scr[4*k +: 4] + 4'd3) : r_scr[4*k +: 4];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a DONE exit never accepts a new input on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // Datapath: load/saturate on accept, shift while converting, publish on last shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_scr      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_out_bcd  <= '0;
            r_out_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_shift    <= (in_bin > c_MAX) ? c_MAX : in_bin;
            r_ovf_pend <= (in_bin > c_MAX);
            r_scr      <= '0;
            r_cnt      <= c_CNT_INIT;
        end else if (r_state == S_SHIFT) begin
            r_scr   <= w_scr_nxt;
            r_shift <= {r_shift[BIN_W-2:0], 1'b0};
            r_cnt   <= r_cnt - c_CNT_LAST;
            if (w_last) begin
                r_out_bcd <= w_scr_nxt;
                r_out_ovf <= r_ovf_pend;
            end
        end
    end

    assign out_bcd = r_out_bcd;
    assign out_ovf = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd_conv
//  Purpose  : Self-checking bench for bin_to_bcd_conv against an arithmetic
//             decimal-digit reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bin_to_bcd_conv;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_in_valid = 1'b0;
    logic [BIN_W-1:0]     i_in_bin = '0;
    logic                 i_out_ready = 1'b1;
    logic                 o_in_ready;
    logic                 o_out_valid;
    logic [4*DIGITS-1:0]  o_out_bcd;
    logic                 o_out_ovf;

    int n_checks = 0;
    int n_errs   = 0;
    logic [15:0] last_bcd = '0;

    bin_to_bcd_conv #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (i_in_valid),
        .in_ready  (o_in_ready),
        .in_bin    (i_in_bin),
        .out_valid (o_out_valid),
        .out_ready (i_out_ready),
        .out_bcd   (o_out_bcd),
        .out_ovf   (o_out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: saturate, then peel decimal digits with div/mod.
    function automatic logic [15:0] ref_bcd(input int x);
        int v;
        logic [15:0] r;
        v = (x > MAXV) ? MAXV : x;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a conversion and waits for its result; returns with DUT in DONE.
    task automatic convert(input int val);
        int n;
        n = 0;
        while (!o_in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!o_in_ready) chk("ready_timeout", 0, 1);
        i_in_bin   = BIN_W'(val);
        i_in_valid = 1'b1;
        tick();
        i_in_valid = 1'b0;
        chk("hold_prev", o_out_bcd, last_bcd);
        n = 0;
        while (!o_out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("latency", n, 14);
        chk($sformatf("bcd(%0d)", val), o_out_bcd, ref_bcd(val));
        chk($sformatf("ovf(%0d)", val), o_out_ovf, (val > MAXV) ? 1 : 0);
        last_bcd = ref_bcd(val);
    endtask

    initial begin
        int dirs [$] = '{0, 1, 9, 10, 99, 100, 1234, 999, 1000, 9998, 9999,
                         10000, 12000, 16383};
        // Reset state
        #2;
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_bcd", o_out_bcd, 0);
        chk("rst_ovf", o_out_ovf, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed boundary values
        foreach (dirs[i]) convert(dirs[i]);

        // Reset pulse while idle clears the held result
        convert(16383);
        tick();
        rst = 1'b1;
        #1;
        chk("idle_rst_in_ready", o_in_ready, 1);
        chk("idle_rst_out_valid", o_out_valid, 0);
        chk("idle_rst_bcd", o_out_bcd, 0);
        chk("idle_rst_ovf", o_out_ovf, 0);
        tick();
        rst = 1'b0;
        last_bcd = '0;
        tick();

        // Back-pressure: DONE holds, inputs ignored
        i_out_ready = 1'b0;
        convert(777);
        for (int i = 0; i < 20; i++) begin
            i_in_valid = i[0];
            i_in_bin   = 14'd42;
            tick();
            chk("bp_out_valid", o_out_valid, 1);
            chk("bp_bcd", o_out_bcd, 16'h0777);
            chk("bp_in_ready", o_in_ready, 0);
        end
        // Simultaneous out_ready and in_valid: exit only
        i_in_valid  = 1'b1;
        i_out_ready = 1'b1;
        tick();
        i_in_valid = 1'b0;
        chk("exit_out_valid", o_out_valid, 0);
        chk("exit_in_ready", o_in_ready, 1);
        chk("exit_bcd", o_out_bcd, 16'h0777);

        // Reset mid-conversion
        convert(4321);
        tick();
        i_in_bin   = 14'd55;
        i_in_valid = 1'b1;
        tick();
        i_in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_bcd", o_out_bcd, 0);
        chk("mid_rst_in_ready", o_in_ready, 1);
        chk("mid_rst_out_valid", o_out_valid, 0);
        tick();
        rst = 1'b0;
        last_bcd = '0;
        tick();
        convert(55);

        // Randomized sweep
        for (int i = 0; i < 2500; i++) begin
            convert(int'($urandom_range(16383, 0)));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
